// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types and constants for the memory arbiter.
// Supplies `ADDR_WIDTH / `DATA_WIDTH (12) when the wider build has not already defined them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_IFU  = 2'd0,
    SRC_EXRD = 2'd1,
    SRC_EXWR = 2'd2
  } arb_src_e;

  localparam int ARB_STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/pdp_arb_prio_sel.sv
// Fixed-priority winner select (exec_wr > exec_rd > ifu_rd) with optional IFU starvation guard.
// Build macro: PDP_ARB_STARVE_EN enables the starve counter; otherwise pure fixed priority.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module pdp_arb_prio_sel
  import pdp8_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     ifu_req,
  input  logic     exrd_req,
  input  logic     exwr_req,
  input  logic     grant,
  output logic     any_req,
  output arb_src_e winner
);

  logic starved;

`ifdef PDP_ARB_STARVE_EN
  logic [3:0] starve_cnt;

  // Counts exec grants taken while the IFU waits; any IFU grant or idle IFU restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!ifu_req) begin
      starve_cnt <= '0;
    end else if (grant) begin
      starve_cnt <= (winner == SRC_IFU) ? 4'd0 : starve_cnt + 4'd1;
    end
  end

  assign starved = ifu_req && (starve_cnt == 4'(STARVE_LIMIT));
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, reset_n, grant};
  assign starved = 1'b0;
`endif

  assign any_req = ifu_req | exrd_req | exwr_req;

  always_comb begin
    winner = SRC_IFU;
    if (starved)       winner = SRC_IFU;
    else if (exwr_req) winner = SRC_EXWR;
    else if (exrd_req) winner = SRC_EXRD;
  end

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Shares one single-port synchronous memory between the IFU fetch port and exec read/write ports.
// Build macro: PDP_ARB_STARVE_EN (IFU starvation guard, see pdp_arb_prio_sel).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ifu_rd_req,
  input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [`DATA_WIDTH-1:0] ifu_rd_data,
  output logic                   ifu_rd_vld,
  input  logic                   exec_rd_req,
  input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [`DATA_WIDTH-1:0] exec_rd_data,
  output logic                   exec_rd_vld,
  input  logic                   exec_wr_req,
  input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [`DATA_WIDTH-1:0] exec_wr_data,
  output logic                   exec_wr_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [`ADDR_WIDTH-1:0] mem_addr,
  output logic [`DATA_WIDTH-1:0] mem_wdata,
  input  logic [`DATA_WIDTH-1:0] mem_rdata,
  output arb_state_e             arb_state
);

  // Handshake: each req is a level held until its one-cycle vld/ack pulse; the requester
  // drops it on the edge ending that pulse, and a req still high in IDLE is a new transaction.

  arb_state_e             state, state_nx;
  arb_src_e               src, winner;
  logic                   any_req, grant;
  logic [`ADDR_WIDTH-1:0] sel_addr;

  pdp_arb_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio_sel (
    .clk      (clk),
    .reset_n  (reset_n),
    .ifu_req  (ifu_rd_req),
    .exrd_req (exec_rd_req),
    .exwr_req (exec_wr_req),
    .grant    (grant),
    .any_req  (any_req),
    .winner   (winner)
  );

  assign grant     = (state == IDLE) && any_req;
  assign arb_state = state;

  always_comb begin
    sel_addr = ifu_rd_addr;
    case (winner)
      SRC_EXWR: sel_addr = exec_wr_addr;
      SRC_EXRD: sel_addr = exec_rd_addr;
      default:  sel_addr = ifu_rd_addr;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = (src == SRC_EXWR) ? RESP : WAIT;
      WAIT:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // mem_* are loaded at the grant edge so they are valid exactly during ISSUE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      src          <= SRC_IFU;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ifu_rd_data  <= '0;
      ifu_rd_vld   <= 1'b0;
      exec_rd_data <= '0;
      exec_rd_vld  <= 1'b0;
      exec_wr_ack  <= 1'b0;
    end else begin
      state       <= state_nx;
      if (grant) src <= winner;
      mem_req     <= grant;
      mem_we      <= grant && (winner == SRC_EXWR);
      mem_addr    <= grant ? sel_addr : '0;
      mem_wdata   <= (grant && (winner == SRC_EXWR)) ? exec_wr_data : '0;
      ifu_rd_vld  <= (state == WAIT) && (src == SRC_IFU);
      exec_rd_vld <= (state == WAIT) && (src == SRC_EXRD);
      exec_wr_ack <= (state == ISSUE) && (src == SRC_EXWR);
      if ((state == WAIT) && (src == SRC_IFU))  ifu_rd_data  <= mem_rdata;
      if ((state == WAIT) && (src == SRC_EXRD)) exec_rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Directed bench for pdp_mem_arbiter with a single-port synchronous memory model.
// Expectation for the starvation scenario follows PDP_ARB_STARVE_EN.
`timescale 1ns/1ps

module tb_pdp_mem_arbiter;
  import pdp8_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        ifu_rd_vld;
  logic        exec_rd_req;
  logic [11:0] exec_rd_addr;
  logic [11:0] exec_rd_data;
  logic        exec_rd_vld;
  logic        exec_wr_req;
  logic [11:0] exec_wr_addr;
  logic [11:0] exec_wr_data;
  logic        exec_wr_ack;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  arb_state_e  arb_state;

  int checks   = 0;
  int failures = 0;

  logic [11:0] mem [0:4095];
  logic [3:0]  flags;

  assign flags = {mem_req, ifu_rd_vld, exec_rd_vld, exec_wr_ack};

  always #5 clk = ~clk;

  pdp_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ifu_rd_req   (ifu_rd_req),
    .ifu_rd_addr  (ifu_rd_addr),
    .ifu_rd_data  (ifu_rd_data),
    .ifu_rd_vld   (ifu_rd_vld),
    .exec_rd_req  (exec_rd_req),
    .exec_rd_addr (exec_rd_addr),
    .exec_rd_data (exec_rd_data),
    .exec_rd_vld  (exec_rd_vld),
    .exec_wr_req  (exec_wr_req),
    .exec_wr_addr (exec_wr_addr),
    .exec_wr_data (exec_wr_data),
    .exec_wr_ack  (exec_wr_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .arb_state    (arb_state)
  );

  // Memory model: read data appears the cycle after a read strobe; reset reloads the preset image.
  always @(posedge clk) begin
    if (!reset_n) begin
      mem[12'o0200] <= 12'o7001;
      mem[12'o0050] <= 12'o0000;
      mem_rdata     <= '0;
    end else if (mem_req) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int  n_ex;
    int  ex_before;
    bit  ifu_seen;
    bit  got;

    reset_n      = 1'b0;
    ifu_rd_req   = 1'b0;
    ifu_rd_addr  = '0;
    exec_rd_req  = 1'b0;
    exec_rd_addr = '0;
    exec_wr_req  = 1'b0;
    exec_wr_addr = '0;
    exec_wr_data = '0;
    tick();
    tick();

    // Reset state
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_ifu_data", 32'(ifu_rd_data), 32'h0);
    chk("rst_exrd_data", 32'(exec_rd_data), 32'h0);
    chk("rst_state", 32'(arb_state), 32'(IDLE));
    reset_n = 1'b1;
    tick();

    // Lone IFU read
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = 12'o0200;
    tick();
    chk("ifu_c1_flags", 32'(flags), 32'b1000);
    chk("ifu_c1_we", 32'(mem_we), 32'h0);
    chk("ifu_c1_addr", 32'(mem_addr), 32'(12'o0200));
    tick();
    chk("ifu_c2_flags", 32'(flags), 32'b0000);
    tick();
    chk("ifu_c3_flags", 32'(flags), 32'b0100);
    chk("ifu_c3_data", 32'(ifu_rd_data), 32'(12'o7001));
    ifu_rd_req = 1'b0;
    tick();
    chk("ifu_c4_flags", 32'(flags), 32'b0000);
    chk("ifu_c4_state", 32'(arb_state), 32'(IDLE));
    chk("ifu_hold_data", 32'(ifu_rd_data), 32'(12'o7001));

    // exec_wr and IFU together: write first, then IFU
    exec_wr_req  = 1'b1;
    exec_wr_addr = 12'o0050;
    exec_wr_data = 12'o1234;
    ifu_rd_req   = 1'b1;
    ifu_rd_addr  = 12'o0200;
    tick();
    chk("wi_c1_flags", 32'(flags), 32'b1000);
    chk("wi_c1_we", 32'(mem_we), 32'h1);
    chk("wi_c1_addr", 32'(mem_addr), 32'(12'o0050));
    chk("wi_c1_wdata", 32'(mem_wdata), 32'(12'o1234));
    tick();
    chk("wi_c2_ack", 32'(flags), 32'b0001);
    exec_wr_req = 1'b0;
    tick();
    chk("wi_c3_flags", 32'(flags), 32'b0000);
    tick();
    chk("wi_c4_flags", 32'(flags), 32'b1000);
    chk("wi_c4_we", 32'(mem_we), 32'h0);
    chk("wi_c4_addr", 32'(mem_addr), 32'(12'o0200));
    tick();
    chk("wi_c5_flags", 32'(flags), 32'b0000);
    tick();
    chk("wi_c6_flags", 32'(flags), 32'b0100);
    chk("wi_c6_data", 32'(ifu_rd_data), 32'(12'o7001));
    chk("wi_mem_written", 32'(mem[12'o0050]), 32'(12'o1234));
    ifu_rd_req = 1'b0;
    tick();

    // Short reset: clears read data registers and reloads memory image
    reset_n = 1'b0;
    tick();
    chk("rst2_ifu_data", 32'(ifu_rd_data), 32'h0);
    chk("rst2_flags", 32'(flags), 32'h0);
    reset_n = 1'b1;
    tick();

    // exec_wr and exec_rd together to same address
    exec_wr_req  = 1'b1;
    exec_wr_addr = 12'o0050;
    exec_wr_data = 12'o1234;
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o0050;
    tick();
    chk("wr_c1_we", 32'(mem_we), 32'h1);
    chk("wr_c1_flags", 32'(flags), 32'b1000);
    tick();
    chk("wr_c2_ack", 32'(flags), 32'b0001);
    exec_wr_req = 1'b0;
    tick();
    chk("wr_c3_flags", 32'(flags), 32'b0000);
    tick();
    chk("rd_c4_flags", 32'(flags), 32'b1000);
    chk("rd_c4_we", 32'(mem_we), 32'h0);
    chk("rd_c4_addr", 32'(mem_addr), 32'(12'o0050));
    tick();
    tick();
    chk("rd_c6_flags", 32'(flags), 32'b0010);
    chk("rd_c6_data", 32'(exec_rd_data), 32'(12'o1234));
    exec_rd_req = 1'b0;
    tick();

    // IFU held while exec_rd is continuously requested
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o0050;
    ifu_rd_req   = 1'b1;
    ifu_rd_addr  = 12'o0200;
    n_ex      = 0;
    ex_before = -1;
    ifu_seen  = 1'b0;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (exec_rd_vld) n_ex++;
      if (ifu_rd_vld && !ifu_seen) begin
        ifu_seen   = 1'b1;
        ex_before  = n_ex;
        ifu_rd_req = 1'b0;
      end
    end
`ifdef PDP_ARB_STARVE_EN
    chk("starve_ifu_served", 32'(ifu_seen), 32'h1);
    chk("starve_ex_before", 32'(ex_before), 32'd4);
`else
    chk("fixed_ifu_never", 32'(ifu_seen), 32'h0);
    chk("fixed_ex_count", 32'(n_ex), 32'd12);
`endif
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      tick();
      if (exec_rd_vld) got = 1'b1;
    end
    chk("starve_drain_vld", 32'(got), 32'h1);
    exec_rd_req = 1'b0;
    ifu_rd_req  = 1'b0;
    tick();
    tick();
    chk("starve_end_state", 32'(arb_state), 32'(IDLE));
    chk("starve_end_flags", 32'(flags), 32'h0);

    // Reset during WAIT of an exec read
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o0050;
    tick();
    chk("rw_c1_flags", 32'(flags), 32'b1000);
    tick();
    chk("rw_c2_state", 32'(arb_state), 32'(WAIT));
    reset_n     = 1'b0;
    exec_rd_req = 1'b0;
    tick();
    chk("rw_flags", 32'(flags), 32'h0);
    chk("rw_exrd_data", 32'(exec_rd_data), 32'h0);
    chk("rw_mem_addr", 32'(mem_addr), 32'h0);
    chk("rw_mem_we", 32'(mem_we), 32'h0);
    chk("rw_state", 32'(arb_state), 32'(IDLE));
    reset_n      = 1'b1;
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o0200;
    tick();
    chk("fr_c1_flags", 32'(flags), 32'b1000);
    tick();
    chk("fr_c2_flags", 32'(flags), 32'b0000);
    tick();
    chk("fr_c3_flags", 32'(flags), 32'b0010);
    chk("fr_c3_data", 32'(exec_rd_data), 32'(12'o7001));
    exec_rd_req = 1'b0;
    tick();

    // Idle with no requests
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_flags", 32'(flags), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
